// File: rtl/fp_byte_serializer.sv
// Byte-serial transmitter for 32-bit FP words: MSB byte first, one byte per clock,
// with a one-word holding buffer so consecutive words stream without a bubble.
module fp_byte_serializer #(
  parameter int WORD_W = 32,
  parameter int BYTE_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] FP_in,
  input  logic              load,
  output logic              ready,
  output logic [BYTE_W-1:0] Dout,
  output logic              Dout_valid,
  output logic              Dout_last,
  output logic              word_sel
);
  localparam int BYTES = WORD_W / BYTE_W;
  localparam int CW    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(BYTES - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state, n_state;
  logic [WORD_W-1:0] sreg, n_sreg;
  logic [WORD_W-1:0] hold, n_hold;
  logic              hold_full, n_full;
  logic [CW-1:0]     cnt, n_cnt;
  logic              ws, n_ws;
  logic              last_q;
  logic              accept, on_last;

  assign ready   = !hold_full;
  assign accept  = load && ready;
  assign on_last = (state == SEND) && (cnt == LAST_IDX);

  always_comb begin
    n_state = state;
    n_sreg  = sreg;
    n_hold  = hold;
    n_full  = hold_full;
    n_cnt   = cnt;
    n_ws    = ws;
    case (state)
      IDLE: begin
        if (accept) begin
          n_sreg  = FP_in;
          n_cnt   = '0;
          n_state = SEND;
        end
      end
      SEND: begin
        if (!on_last) begin
          n_sreg = sreg << BYTE_W;
          n_cnt  = cnt + 1'b1;
          if (accept) begin
            n_hold = FP_in;
            n_full = 1'b1;
          end
        end else begin
          // word boundary: refill from buffer first, else a same-cycle load, else go idle
          n_ws  = !ws;
          n_cnt = '0;
          if (hold_full) begin
            n_sreg = hold;
            n_hold = '0;
            n_full = 1'b0;
          end else if (accept) begin
            n_sreg = FP_in;
          end else begin
            n_sreg  = '0;
            n_state = IDLE;
          end
        end
      end
      default: n_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      sreg      <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      cnt       <= '0;
      ws        <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      state     <= n_state;
      sreg      <= n_sreg;
      hold      <= n_hold;
      hold_full <= n_full;
      cnt       <= n_cnt;
      ws        <= n_ws;
      last_q    <= (n_state == SEND) && (n_cnt == LAST_IDX);
    end
  end

  assign Dout       = sreg[WORD_W-1 -: BYTE_W];
  assign Dout_valid = (state == SEND);
  assign Dout_last  = last_q;
  assign word_sel   = ws;
endmodule

// File: tb/tb_fp_byte_serializer.sv
// Directed bench for fp_byte_serializer; a receiver-side shift register rebuilds word pairs.
module tb_fp_byte_serializer;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] FP_in = '0;
  logic        load = 1'b0;
  logic        ready;
  logic [7:0]  Dout;
  logic        Dout_valid, Dout_last, word_sel;
  logic [63:0] rx = '0;

  int n_pass = 0;
  int n_tot  = 0;

  fp_byte_serializer dut (
    .clk(clk), .reset(reset), .FP_in(FP_in), .load(load), .ready(ready),
    .Dout(Dout), .Dout_valid(Dout_valid), .Dout_last(Dout_last), .word_sel(word_sel)
  );

  always #5 clk = ~clk;

  // downstream capture: FP_1 in rx[63:32], FP_2 in rx[31:0]
  always @(posedge clk) if (Dout_valid) rx <= {rx[55:0], Dout};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tot++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_chk(input string tag, input logic ws);
    chk({tag, "_vld"}, 64'(Dout_valid), 64'(0));
    chk({tag, "_dout"}, 64'(Dout), 64'(0));
    chk({tag, "_last"}, 64'(Dout_last), 64'(0));
    chk({tag, "_ws"}, 64'(word_sel), 64'(ws));
  endtask

  task automatic byte_chk(input string tag, input logic [7:0] b, input logic l, input logic ws);
    chk({tag, "_byte"}, 64'(Dout), 64'(b));
    chk({tag, "_vld"}, 64'(Dout_valid), 64'(1));
    chk({tag, "_last"}, 64'(Dout_last), 64'(l));
    chk({tag, "_ws"}, 64'(word_sel), 64'(ws));
  endtask

  // load for one cycle; returns with the MSB byte on the bus
  task automatic load_word(input string tag, input logic [31:0] w);
    load = 1'b1; FP_in = w;
    chk({tag, "_rdy"}, 64'(ready), 64'(1));
    tick();
    load = 1'b0; FP_in = '0;
  endtask

  // checks the four bytes, leaving the bench on the last-byte cycle
  task automatic word_out(input string tag, input logic [31:0] w, input logic ws);
    for (int i = 0; i < 4; i++) begin
      byte_chk(tag, w[31-8*i -: 8], (i == 3), ws);
      if (i < 3) tick();
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    #2;
    tick();
    idle_chk("rst", 1'b0);
    chk("rst_rdy", 64'(ready), 64'(1));
    reset = 1'b1;
    tick();

    // single word
    load_word("w1", 32'h3F80_0000);
    word_out("w1", 32'h3F80_0000, 1'b0);
    tick();
    idle_chk("w1_after", 1'b1);

    // back-to-back pair, second load on the 2nd byte cycle
    load_word("p", 32'h4049_0FDB);
    byte_chk("p0", 8'h40, 1'b0, 1'b1);
    tick();
    byte_chk("p1", 8'h49, 1'b0, 1'b1);
    load_word("p2ld", 32'hC020_0000);
    byte_chk("p2", 8'h0F, 1'b0, 1'b1);
    tick();
    byte_chk("p3", 8'hDB, 1'b1, 1'b1);
    tick();
    word_out("pB", 32'hC020_0000, 1'b0);
    tick();
    chk("pair_rx", rx, 64'h4049_0FDB_C020_0000);
    idle_chk("p_after", 1'b1);

    // load on the last-byte cycle with empty buffer
    load_word("l", 32'h1122_3344);
    word_out("lA", 32'h1122_3344, 1'b1);
    load_word("lBld", 32'h5566_7788);
    word_out("lB", 32'h5566_7788, 1'b0);
    tick();
    chk("last_rx", rx, 64'h1122_3344_5566_7788);
    idle_chk("l_after", 1'b1);

    // buffer-full backpressure: C presented while B is buffered, then withdrawn
    load_word("bA", 32'hAAAA_AAAA);
    byte_chk("bA0", 8'hAA, 1'b0, 1'b1);
    load_word("bBld", 32'hBBBB_BBBB);
    byte_chk("bA1", 8'hAA, 1'b0, 1'b1);
    load = 1'b1; FP_in = 32'hCCCC_CCCC;
    chk("bC_rdy1", 64'(ready), 64'(0));
    tick();
    byte_chk("bA2", 8'hAA, 1'b0, 1'b1);
    chk("bC_rdy2", 64'(ready), 64'(0));
    tick();
    byte_chk("bA3", 8'hAA, 1'b1, 1'b1);
    chk("bC_rdy3", 64'(ready), 64'(0));
    tick();
    load = 1'b0; FP_in = '0;
    word_out("bB", 32'hBBBB_BBBB, 1'b0);
    tick();
    idle_chk("b_after", 1'b1);
    tick();
    idle_chk("b_noC", 1'b1);

    // asynchronous reset mid-word
    load_word("r", 32'hDEAD_BEEF);
    byte_chk("r0", 8'hDE, 1'b0, 1'b1);
    tick();
    byte_chk("r1", 8'hAD, 1'b0, 1'b1);
    #2 reset = 1'b0;
    #1;
    idle_chk("r_async", 1'b0);
    chk("r_rdy", 64'(ready), 64'(1));
    @(posedge clk); #1;
    reset = 1'b1;
    tick();
    idle_chk("r_rel", 1'b0);
    load_word("r2", 32'h0000_0001);
    word_out("r2", 32'h0000_0001, 1'b0);
    tick();
    idle_chk("r2_after", 1'b1);

    // idle gap between two words, starting from fresh reset
    do_reset();
    load_word("g1", 32'h1234_5678);
    word_out("g1", 32'h1234_5678, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      idle_chk("gap", 1'b1);
    end
    load_word("g2", 32'h9ABC_DEF0);
    word_out("g2", 32'h9ABC_DEF0, 1'b1);
    tick();
    idle_chk("g_after", 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end
endmodule

// File: doc/fp_byte_serializer.md
Name: fp_byte_serializer

Overview:
- Transmit side of the byte-serial floating-point channel: accepts 32-bit single-precision words and emits them one byte per clock on an 8-bit bus, MSB byte first.
- The downstream byte-shift register capture reconstructs the words: first word into FP_1, second into FP_2.
- A one-word holding buffer lets back-to-back words stream with no idle cycle, so a pair arrives in 8 consecutive byte cycles.

Parameters:
- WORD_W, 32, word width in bits; must be an integer multiple of BYTE_W.
- BYTE_W, 8, serial byte width in bits.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- FP_in  input  WORD_W  word to transmit.
- load  input  1  request to accept FP_in this cycle.
- ready  output  1  high when a load this cycle is accepted.
- Dout  output  BYTE_W  serial byte.
- Dout_valid  output  1  Dout carries a valid byte this cycle.
- Dout_last  output  1  high with the final (LSB) byte of a word.
- word_sel  output  1  0 = current/next byte belongs to FP_1 slot, 1 = FP_2 slot.

Behaviour:
- Reset (reset=0, any time, including mid-word):
  - shift register, holding buffer and byte counter clear.
  - Dout=0, Dout_valid=0, Dout_last=0, word_sel=0, ready=1.
  - A partially sent word is discarded and is not resumed after reset.
- Definitions:
  - BYTES = WORD_W/BYTE_W (4 by default).
  - cnt = 2-bit byte index (log2(BYTES) bits in general).
  - States: IDLE (shift register empty) and SEND.
- ready is combinational: ready = !hold_full. An accepted load is load && ready.
- IDLE + accepted load at edge N:
  - FP_in goes into the shift register and state becomes SEND.
  - After edge N: Dout = FP_in[31:24], Dout_valid=1, cnt=0.
  - Latency is one clock from load to first byte.
- SEND, each edge:
  - Shift left by BYTE_W and increment cnt.
  - Bytes appear in the order [31:24], [23:16], [15:8], [7:0] on consecutive cycles.
  - Dout_last=1 exactly on the cycle cnt=BYTES-1.
- SEND + accepted load while not on the last byte: FP_in goes into the holding buffer and hold_full=1.
- End of the last-byte cycle:
  - If hold_full: the holding buffer moves to the shift register, hold_full clears, and the next cycle outputs its MSB byte (no bubble).
  - Else if an accepted load is present the same cycle: FP_in goes directly to the shift register (no bubble).
  - Else: return to IDLE. Next cycle Dout_valid=0 and Dout=0.
- Load on the last-byte cycle while hold_full=1: ready=0, so the load is ignored. The buffered word is sent next; the caller must hold load.
- load while ready=0 is ignored. FP_in is don't-care when load=0.
- word_sel:
  - Toggles on the edge after every Dout_last cycle.
  - Is constant for all 4 bytes of a word.
  - Sequence 0,1,0,1 across successive words.
  - Does not toggle in IDLE.
- Dout_valid stays high continuously across back-to-back words. There are no gaps while data is available.
- All outputs except ready are registered.

Test Plan:
- Reset then one word:
  - Stimulus: load FP_in=32'h3F80_0000 for 1 cycle.
  - Response: Dout = 3F,80,00,00 on the next 4 cycles; Dout_valid=1 for exactly 4 cycles; Dout_last on byte 00 (4th); word_sel=0 throughout, becomes 1 afterwards.
- Back-to-back pair:
  - Stimulus: load 32'h4049_0FDB, then load 32'hC020_0000 on the 2nd byte cycle.
  - Response: 8 contiguous valid bytes 40,49,0F,DB,C0,20,00,00. Feeding them to the receiving shift register yields FP_1=4049_0FDB, FP_2=C020_0000 at the 8th edge.
- Load on last-byte cycle with empty buffer:
  - Stimulus: load 32'h1122_3344, then load 32'h5566_7788 exactly when Dout_last=1.
  - Response: bytes 11,22,33,44,55,66,77,88 with no bubble; ready=1 on that cycle.
- Buffer full backpressure:
  - Stimulus: send A=32'hAAAA_AAAA; buffer B=32'hBBBB_BBBB; attempt C=32'hCCCC_CCCC while hold_full.
  - Response: ready=0 during the attempt; output is AA×4, BB×4; C is not sent unless re-presented after ready=1.
- Reset mid-word:
  - Stimulus: assert reset asynchronously after the 2nd byte of 32'hDEAD_BEEF.
  - Response: outputs zero immediately, ready=1, word_sel=0; after release a new load of 32'h0000_0001 sends 00,00,00,01.
- Idle gap:
  - Stimulus: a word, 3 idle cycles, another word.
  - Response: Dout_valid=0 and Dout=0 during the gap; word_sel is 1 for the second word.
